// File: rtl/ps2_scan_receiver_if.sv
// PS/2 receiver bus: raw connector lines in, decoded scan code and status strobes out.
// master drives the PS/2 lines (device side); slave is the receiver.
interface ps2_scan_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid;
    logic       code_break;
    logic       code_ext;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  code, code_valid, code_break, code_ext, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output code, code_valid, code_break, code_ext, frame_err
    );
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver: sync, deglitch, deserialise, parity/stop check, E0/F0 prefix folding.
// Optional `define PS2_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYCLES clk cycles without a falling edge.
module ps2_scan_receiver #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_scan_receiver_if.slave   bus_io
);

    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
    logic                   filt_q, filt_d;
    logic [1:0]             state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   ext_pend_q, ext_pend_d;
    logic                   brk_pend_q, brk_pend_d;
    logic [7:0]             code_q, code_d;
    logic                   code_valid_q, code_valid_d;
    logic                   code_break_q, code_break_d;
    logic                   code_ext_q, code_ext_d;
    logic                   frame_err_q, frame_err_d;

    logic clk_s_c, dat_s_c, fall_c;

`ifdef PS2_TIMEOUT_EN
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout_c;
    assign unused_timeout_c = ^TW;
`endif

    assign bus_io.code       = code_q;
    assign bus_io.code_valid = code_valid_q;
    assign bus_io.code_break = code_break_q;
    assign bus_io.code_ext   = code_ext_q;
    assign bus_io.frame_err  = frame_err_q;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            filt_cnt_q   <= '0;
            filt_q       <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            code_break_q <= 1'b0;
            code_ext_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_cnt_q   <= filt_cnt_d;
            filt_q       <= filt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            code_break_q <= code_break_d;
            code_ext_q   <= code_ext_d;
            frame_err_q  <= frame_err_d;
`ifdef PS2_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    // Front end, frame FSM and output update
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], bus_io.ps2_clk};
        dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0], bus_io.ps2_data};
        clk_s_c      = clk_sync_q[SYNC_STAGES-1];
        dat_s_c      = dat_sync_q[SYNC_STAGES-1];
        filt_cnt_d   = filt_cnt_q;
        filt_d       = filt_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        code_break_d = code_break_q;
        code_ext_d   = code_ext_q;
        frame_err_d  = 1'b0;

        // Filtered clock flips on the FILTER_LEN-th consecutive differing sample
        if (clk_s_c == filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d     = clk_s_c;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + FCW'(1);
        end
        fall_c = filt_q & ~filt_d;

        case (state_q)
            S_IDLE: begin
                if (fall_c && !dat_s_c) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (fall_c) begin
                    shift_d = {dat_s_c, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (fall_c) begin
                    par_d   = dat_s_c;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_c) begin
                    state_d = S_IDLE;
                    if ((^{shift_q, par_q}) && dat_s_c) begin
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_pend_d = 1'b1;
                        end else begin
                            code_d       = shift_q;
                            code_break_d = brk_pend_q;
                            code_ext_d   = ext_pend_q;
                            code_valid_d = 1'b1;
                            ext_pend_d   = 1'b0;
                            brk_pend_d   = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef PS2_TIMEOUT_EN
        // Abort an open frame when the line stalls; a fall always restarts the count
        if (state_q == S_IDLE || fall_c) to_cnt_d = '0;
        else                             to_cnt_d = to_cnt_q + TW'(1);
        if (state_q != S_IDLE && !fall_c && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = S_IDLE;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
            frame_err_d = 1'b1;
            to_cnt_d    = '0;
        end
`endif
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: frames driven bit by bit, strobes counted by a monitor.
// Define PS2_TIMEOUT_EN to also exercise the stall abort.
module tb_ps2_scan_receiver;

    localparam int unsigned HALF = 20;
    localparam int unsigned TO   = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   valid_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   v0, e0;

    ps2_scan_receiver_if bus ();

    ps2_scan_receiver #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.code_valid) valid_cnt <= valid_cnt + 1;
        if (bus.frame_err)  err_cnt   <= err_cnt + 1;
        if (bus.code_valid && bus.frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop);
        logic par;
        par = ~(^b) ^ flip_par;
        send_bits({stop, par, b, 1'b0}, 11);
        repeat (HALF) @(negedge clk);
    endtask

    task automatic mark();
        @(negedge clk);
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    task automatic chk_out(input string tag, input int nv, input int ne,
                           input logic [7:0] c, input logic b, input logic x);
        repeat (4) @(negedge clk);
        chk({tag, "_valid_n"}, 32'(valid_cnt - v0), 32'(nv));
        chk({tag, "_err_n"},   32'(err_cnt - e0),   32'(ne));
        chk({tag, "_code"},    32'(bus.code),       32'(c));
        chk({tag, "_break"},   32'(bus.code_break), 32'(b));
        chk({tag, "_ext"},     32'(bus.code_ext),   32'(x));
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_code",  32'(bus.code),       32'h0);
        chk("rst_valid", 32'(bus.code_valid), 32'h0);
        chk("rst_break", 32'(bus.code_break), 32'h0);
        chk("rst_ext",   32'(bus.code_ext),   32'h0);
        chk("rst_err",   32'(bus.frame_err),  32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: plain make code
        mark(); send_frame(8'h1C, 1'b0, 1'b1);
        chk_out("t1", 1, 0, 8'h1C, 1'b0, 1'b0);

        // 2: extended, then plain same byte
        mark(); send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'h75, 1'b0, 1'b1);
        chk_out("t2a", 1, 0, 8'h75, 1'b0, 1'b1);
        mark(); send_frame(8'h75, 1'b0, 1'b1);
        chk_out("t2b", 1, 0, 8'h75, 1'b0, 1'b0);

        // 3: extended break, then plain
        mark(); send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h6B, 1'b0, 1'b1);
        chk_out("t3a", 1, 0, 8'h6B, 1'b1, 1'b1);
        mark(); send_frame(8'h74, 1'b0, 1'b1);
        chk_out("t3b", 1, 0, 8'h74, 1'b0, 1'b0);

        // 4: parity error keeps previous code; bad frame clears pending break
        mark(); send_frame(8'h72, 1'b1, 1'b1);
        chk_out("t4a", 0, 1, 8'h74, 1'b0, 1'b0);
        mark(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'h72, 1'b0, 1'b1);
        chk_out("t4b", 1, 1, 8'h72, 1'b0, 1'b0);

        // 5: short clock glitch is filtered out
        mark();
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        repeat (2) @(negedge clk);
        bus.ps2_clk  = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.ps2_data = 1'b1;
        send_frame(8'h29, 1'b0, 1'b1);
        chk_out("t5", 1, 0, 8'h29, 1'b0, 1'b0);

`ifdef PS2_TIMEOUT_EN
        // 6a: stalled frame aborts once
        mark(); send_bits(11'b000_0101_0100, 5);
        repeat (TO + 50) @(negedge clk);
        chk_out("t6a", 0, 1, 8'h29, 1'b0, 1'b0);
        mark(); send_frame(8'h75, 1'b0, 1'b1);
        chk_out("t6b", 1, 0, 8'h75, 1'b0, 1'b0);
`endif

        // 6c: reset mid-frame clears everything and discards the frame
        mark(); send_bits(11'b000_0101_0100, 5);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6c_code",  32'(bus.code),       32'h0);
        chk("t6c_break", 32'(bus.code_break), 32'h0);
        chk("t6c_ext",   32'(bus.code_ext),   32'h0);
        chk("t6c_err",   32'(bus.frame_err),  32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h75, 1'b0, 1'b1);
        chk_out("t6d", 1, 0, 8'h75, 1'b0, 1'b0);

        chk("never_both", 32'(both_cnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
